stream_demux_rr: RTL and testbench
==================================

# stream_demux_rr

Parametrised 1-to-N stream demultiplexer with registered per-channel output slots and valid/ready handshaking on both sides. It is the successor of the combinational 1-to-8 demux and distributes words from one producer to N consumers. Steering is either explicit (select input) or automatic round-robin. Each output holds its word until its consumer accepts it, so a stalled channel blocks only traffic addressed to that channel.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `N`, default 8: number of output channels, 2..16; need not be a power of two.
- `SEL_W`, default `$clog2(N)`: width of select and pointer fields.

Ports, clock and reset first:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  block accepts the word this cycle; combinational.
- `sel`  in  SEL_W  target channel when `mode`=0.
- `mode`  in  1  0 = select-steered, 1 = round-robin.
- `out_data`  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  N  channel k slot holds a word.
- `out_ready`  in  N  consumer k takes the word.
- `rr_ptr`  out  SEL_W  next round-robin target, registered.

## Operation
- Target: `tgt = mode ? rr_ptr : sel`.
- `in_ready = tgt_ok && (!out_valid[tgt] || out_ready[tgt])`.
  - `tgt_ok` is 0 when `sel` ≥ N in mode 0.
  - An out-of-range `sel` is never accepted and never corrupts any slot.
- Accept: `in_valid && in_ready`. On accept, `slot[tgt] <= in_data` and `out_valid[tgt] <= 1`.
- Drain of channel k: `out_valid[k] && out_ready[k]`. With no simultaneous load to k, `out_valid[k] <= 0`.
  - `out_data[k]` keeps its last value; it is don't-care while invalid but must not change.
- Simultaneous drain and load on the same channel: load wins, `out_valid` stays 1, new word replaces old. This gives full throughput.
- Channels other than `tgt` drain independently every cycle.
- `rr_ptr`:
  - advances only on accept with `mode`=1;
  - wraps N-1 → 0;
  - holds in mode 0 and across mode changes.
- A `mode` toggle takes effect combinationally in the same cycle. There is no pending state to flush.
- Reset values: `out_valid`=0, all `out_data`=0, `rr_ptr`=0, hence `in_ready`=1 in mode 0 with valid `sel`.
- Reset mid-operation: held words are discarded, no output asserts afterwards, and `rr_ptr` returns to 0.

## Timing
- Latency: a word accepted on edge t is visible on `out_data`/`out_valid` after edge t; that is one cycle.
- Throughput: one word per cycle when the target consumer keeps `out_ready`=1, or when targets differ per cycle.
- `in_ready` depends combinationally on `sel`, `mode`, `out_valid`, `out_ready`. It has no path from `in_valid` and no combinational loop.
- `out_valid`, `out_data`, `rr_ptr` are pure registers. No output is combinational from inputs except `in_ready`.
- Producer must hold `in_data`/`in_valid` stable until accepted. Consumer k sees `out_data[k]` stable while `out_valid[k]`=1 and `out_ready[k]`=0.

## Structure
- Package `demux_pkg`: `MODE_SEL`=1'b0, `MODE_RR`=1'b1, and a `ptr_next(ptr, n)` wrap function.
- Sub-module `demux_slot`: one WIDTH-bit register plus valid flag.
  - Inputs: `load`, `drain`, `d`. Outputs: `q`, `valid`.
  - Instantiated N times in a generate loop.
- Top contains target decode, `in_ready` mux, and the `rr_ptr` register.

## Test plan
- Reset then select sweep: N=8, `mode`=0, all `out_ready`=1, `sel`=0..7 with `in_data`=8'hA0+k → one cycle later `out_valid`=one-hot(k), `out_data[k]`=A0+k, `in_ready` constant 1.
- Backpressure: `sel`=3, `out_ready[3]`=0, send 8'h11 then 8'h22 → 11 held on ch3, `in_ready`=0 during the second offer. Raise `out_ready[3]` → 22 loads the same cycle 11 drains, `out_valid[3]` stays 1. Meanwhile `sel`=5 word 8'h55 is accepted.
- Round-robin wrap: N=5, `mode`=1, 7 words 1..7 → channels 0,1,2,3,4,0,1; `rr_ptr` reads 2 at end. Toggle to mode 0 and back → `rr_ptr` still 2.
- Out-of-range select: N=5, `mode`=0, `sel`=6, `in_valid`=1 → `in_ready`=0, no `out_valid` change.
- Async reset mid-stream: assert `rst` between edges with 3 slots full → `out_valid`=0 and `rr_ptr`=0 immediately, before the next edge.
- Random soak: random `in_valid`/`out_ready`/`sel`/`mode`, scoreboard per channel → every accepted word is delivered in order exactly once, with no loss or duplication.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: steering mode encodings
// and the round-robin pointer wrap helper.
package demux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Next round-robin target; wraps n-1 back to 0 so N need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel slot: a data register plus valid flag. A load in the
// same cycle as a drain wins, which keeps the channel at full throughput.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every variable; no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q & ~drain;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end
  end

  // NOTE: the data register is reset too, because its post-reset value of zero is
  // visible on out_data and consumers may rely on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for state, so every flop samples pre-edge values.
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/stream_demux_rr.sv
// 1-to-N stream demultiplexer with registered per-channel slots, steered by
// an explicit select or by a round-robin pointer.
module stream_demux_rr
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [SEL_W-1:0]   rr_ptr
);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             accept;
  logic [N-1:0]     tgt_oh;
  logic [N-1:0]     load;
  logic [N-1:0]     drain;
  logic [N-1:0]     slot_valid;

  always_comb begin
    tgt    = (mode == MODE_RR) ? rr_ptr_q : sel;
    // Compare at 32 bits so an out-of-range select is caught even when N < 2**SEL_W.
    tgt_ok = (32'(tgt) < 32'(N));
    for (int k = 0; k < N; k++) begin
      tgt_oh[k] = tgt_ok && (32'(tgt) == 32'(k));
    end
    // The one-hot mux never indexes past N-1, so a bad select simply yields 0.
    in_ready = |(tgt_oh & (~slot_valid | out_ready));
    accept   = in_valid && in_ready;
    load     = {N{accept}} & tgt_oh;
    drain    = slot_valid & out_ready;
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode == MODE_RR)) begin
      rr_ptr_d = SEL_W'(ptr_next(32'(rr_ptr_q), N));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .drain (drain[k]),
      .d     (in_data),
      .q     (out_data[k*WIDTH +: WIDTH]),
      .valid (slot_valid[k])
    );
  end

  assign out_valid = slot_valid;
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_stream_demux_rr.sv
// Directed and randomized checks of stream_demux_rr at N=8 and N=5, with a
// per-channel queue scoreboard for the random soak.
module tb_stream_demux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: N=8
  logic [7:0]  a_in_data = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [2:0]  a_sel = '0;
  logic        a_mode = 1'b0;
  logic [63:0] a_out_data;
  logic [7:0]  a_out_valid;
  logic [7:0]  a_out_ready = '1;
  logic [2:0]  a_rr_ptr;

  // Instance B: N=5
  logic [7:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [2:0]  b_sel = '0;
  logic        b_mode = 1'b0;
  logic [39:0] b_out_data;
  logic [4:0]  b_out_valid;
  logic [4:0]  b_out_ready = '1;
  logic [2:0]  b_rr_ptr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux_rr #(.WIDTH(8), .N(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .rr_ptr(a_rr_ptr)
  );

  stream_demux_rr #(.WIDTH(8), .N(5)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .rr_ptr(b_rr_ptr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Soak scoreboard: words accepted but not yet taken, per channel of instance B.
  logic [7:0] mq [5][$];

  initial begin
    int          ptr_m;
    int          tgt;
    logic        exp_rdy;
    logic        pending;
    logic [4:0]  ev;

    #12 rst = 1'b0;
    #1;
    check("rst_valid", a_out_valid, 8'h00);
    check("rst_data", a_out_data, 64'h0);
    check("rst_ptr", a_rr_ptr, 3'd0);
    check("rst_ready", a_in_ready, 1'b1);

    // Select sweep on N=8
    tick();
    a_out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      a_sel      = 3'(k);
      a_in_data  = 8'hA0 + 8'(k);
      a_in_valid = 1'b1;
      #1;
      check("sweep_ready", a_in_ready, 1'b1);
      tick();
      check("sweep_valid", a_out_valid, 64'(1) << k);
      check("sweep_data", a_out_data[k*8 +: 8], 8'hA0 + 8'(k));
    end
    a_in_valid = 1'b0;
    tick();
    check("sweep_drained", a_out_valid, 8'h00);

    // Backpressure on channel 3
    a_out_ready = 8'hF7;
    a_sel       = 3'd3;
    a_in_data   = 8'h11;
    a_in_valid  = 1'b1;
    #1;
    check("bp_first_ready", a_in_ready, 1'b1);
    tick();
    a_in_data = 8'h22;
    #1;
    check("bp_stall", a_in_ready, 1'b0);
    tick();
    check("bp_hold_valid", a_out_valid[3], 1'b1);
    check("bp_hold_data", a_out_data[3*8 +: 8], 8'h11);
    a_sel     = 3'd5;
    a_in_data = 8'h55;
    #1;
    check("bp_other_ready", a_in_ready, 1'b1);
    tick();
    check("bp_other_valid", a_out_valid, 8'h28);
    check("bp_other_data", a_out_data[5*8 +: 8], 8'h55);
    a_sel     = 3'd3;
    a_in_data = 8'h22;
    #1;
    check("bp_stall2", a_in_ready, 1'b0);
    a_out_ready = 8'hFF;
    #1;
    check("bp_release", a_in_ready, 1'b1);
    tick();
    check("bp_reload_valid", a_out_valid, 8'h08);
    check("bp_reload_data", a_out_data[3*8 +: 8], 8'h22);
    a_in_valid = 1'b0;
    tick();
    check("bp_drained", a_out_valid, 8'h00);

    // Round-robin wrap on N=5
    b_out_ready = 5'h1F;
    b_mode      = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      b_in_data  = 8'(i);
      b_in_valid = 1'b1;
      #1;
      check("rr_ptr_pre", b_rr_ptr, 64'((i - 1) % 5));
      tick();
      check("rr_valid", b_out_valid, 64'(1) << ((i - 1) % 5));
      check("rr_data", b_out_data[((i - 1) % 5)*8 +: 8], 64'(i));
    end
    b_in_valid = 1'b0;
    check("rr_ptr_end", b_rr_ptr, 3'd2);
    b_mode = 1'b0;
    tick();
    b_mode = 1'b1;
    tick();
    check("rr_ptr_mode_toggle", b_rr_ptr, 3'd2);

    // Out-of-range select on N=5
    b_mode     = 1'b0;
    b_sel      = 3'd6;
    b_in_data  = 8'hEE;
    b_in_valid = 1'b1;
    #1;
    check("oor_ready", b_in_ready, 1'b0);
    tick();
    check("oor_valid", b_out_valid, 5'h00);
    check("oor_data_intact", b_out_data, 40'h05_04_03_07_06);
    b_in_valid = 1'b0;

    // Async reset with three slots full
    b_out_ready = 5'h00;
    for (int k = 0; k < 3; k++) begin
      b_sel      = 3'(k);
      b_in_data  = 8'hC0 + 8'(k);
      b_in_valid = 1'b1;
      tick();
    end
    b_in_valid = 1'b0;
    check("pre_rst_valid", b_out_valid, 5'h07);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", b_out_valid, 5'h00);
    check("arst_ptr", b_rr_ptr, 3'd0);
    check("arst_data", b_out_data, 40'h0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_valid", b_out_valid, 5'h00);

    // Random soak on N=5 against per-channel queues
    ptr_m   = 0;
    pending = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pending) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_data  = 8'($urandom);
      end
      b_sel       = 3'($urandom_range(0, 7));
      b_mode      = 1'($urandom_range(0, 1));
      b_out_ready = 5'($urandom);
      #1;
      for (int k = 0; k < 5; k++) ev[k] = (mq[k].size() > 0);
      check("soak_valid", b_out_valid, ev);
      for (int k = 0; k < 5; k++) begin
        if (ev[k]) check("soak_data", b_out_data[k*8 +: 8], mq[k][0]);
      end
      check("soak_ptr", b_rr_ptr, 64'(ptr_m));
      tgt     = b_mode ? ptr_m : int'(b_sel);
      exp_rdy = (tgt < 5) && (!ev[tgt] || b_out_ready[tgt]);
      check("soak_ready", b_in_ready, exp_rdy);
      for (int k = 0; k < 5; k++) begin
        if (ev[k] && b_out_ready[k]) void'(mq[k].pop_front());
      end
      if (b_in_valid && exp_rdy) begin
        mq[tgt].push_back(b_in_data);
        if (b_mode) ptr_m = (ptr_m + 1) % 5;
      end
      pending = b_in_valid && !exp_rdy;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
